// File: rtl/reg_file_32x32.sv
// 32x32 architectural register file: two combinational read ports, one write port.
// Define ZERO_REG_EN to hardwire register 0 to zero (writes to it are dropped).

module reg_file_entry #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [DATA_WIDTH-1:0] d,
  output logic [DATA_WIDTH-1:0] q
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  q <= '0;
    else if (we) q <= d;
  end
endmodule

module reg_file_32x32 #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 2**ADDR_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [ADDR_WIDTH-1:0] ADDR_R1,
  input  logic [ADDR_WIDTH-1:0] ADDR_R2,
  input  logic [ADDR_WIDTH-1:0] ADDR_W,
  input  logic [DATA_WIDTH-1:0] DATA_W,
  input  logic                  READ,
  input  logic                  WRITE,
  output logic [DATA_WIDTH-1:0] DATA_R1,
  output logic [DATA_WIDTH-1:0] DATA_R2
);
  typedef struct packed {
    logic                  en;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } wr_req_t;

  wr_req_t                          wr_req;
  logic                             rd_en;
  logic [DEPTH-1:0][DATA_WIDTH-1:0] regs;

  // Simultaneous READ and WRITE is a no-op: neither port acts.
  assign wr_req = '{en: WRITE & ~READ, addr: ADDR_W, data: DATA_W};
  assign rd_en  = READ & ~WRITE;

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
`ifdef ZERO_REG_EN
    if (i == 0) begin : g_zero
      assign regs[i] = '0;
    end else begin : g_store
`else
    begin : g_store
`endif
      logic we;
      assign we = wr_req.en && (wr_req.addr == ADDR_WIDTH'(i));
      reg_file_entry #(.DATA_WIDTH(DATA_WIDTH)) u_entry (
        .clk   (CLK),
        .rst_n (RST),
        .we    (we),
        .d     (wr_req.data),
        .q     (regs[i])
      );
    end
  end

  assign DATA_R1 = rd_en ? regs[ADDR_R1] : '0;
  assign DATA_R2 = rd_en ? regs[ADDR_R2] : '0;
endmodule

// File: tb/tb_reg_file_32x32.sv
// Directed self-checking bench for reg_file_32x32 (honours ZERO_REG_EN for register 0).

module tb_reg_file_32x32;
  logic        CLK = 1'b0;
  logic        RST;
  logic [4:0]  ADDR_R1, ADDR_R2, ADDR_W;
  logic [31:0] DATA_W;
  logic        READ, WRITE;
  logic [31:0] DATA_R1, DATA_R2;

  int checks = 0;
  int errors = 0;

  reg_file_32x32 dut (
    .CLK     (CLK),
    .RST     (RST),
    .ADDR_R1 (ADDR_R1),
    .ADDR_R2 (ADDR_R2),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .READ    (READ),
    .WRITE   (WRITE),
    .DATA_R1 (DATA_R1),
    .DATA_R2 (DATA_R2)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] fill_val(input int i);
`ifdef ZERO_REG_EN
    return (i == 0) ? 32'h0 : 32'(i);
`else
    return 32'(i);
`endif
  endfunction

  initial begin
    RST = 1'b0; READ = 1'b1; WRITE = 1'b0;
    ADDR_R1 = 5'd0; ADDR_R2 = 5'd31; ADDR_W = 5'd0; DATA_W = 32'h0;
    #2;
    chk("rst_hold_r1", DATA_R1, 32'h0);
    chk("rst_hold_r2", DATA_R2, 32'h0);
    #8 RST = 1'b1;

    // Reset contents: every address reads zero
    for (int i = 0; i < 32; i++) begin
      @(negedge CLK);
      ADDR_R1 = 5'(i); ADDR_R2 = 5'(31 - i);
      #2;
      chk($sformatf("rst_r1[%0d]", i), DATA_R1, 32'h0);
      chk($sformatf("rst_r2[%0d]", 31 - i), DATA_R2, 32'h0);
    end

    // Fill register i with i on consecutive edges; outputs idle while READ=0
    READ = 1'b0; WRITE = 1'b1;
    for (int i = 0; i < 32; i++) begin
      @(negedge CLK);
      ADDR_W = 5'(i); DATA_W = 32'(i);
      ADDR_R1 = 5'(i); ADDR_R2 = 5'(i);
      #2;
      if (i == 10 || i == 20) begin
        chk("idle_fill_r1", DATA_R1, 32'h0);
        chk("idle_fill_r2", DATA_R2, 32'h0);
      end
    end

    // Readback through both ports
    @(negedge CLK);
    WRITE = 1'b0; READ = 1'b1;
    for (int i = 0; i < 32; i++) begin
      ADDR_R1 = 5'(i); ADDR_R2 = 5'(i);
      #2;
      chk($sformatf("fill_r1[%0d]", i), DATA_R1, fill_val(i));
      chk($sformatf("fill_r2[%0d]", i), DATA_R2, fill_val(i));
    end

    // Independent ports
    ADDR_R1 = 5'd3; ADDR_R2 = 5'd30;
    #1;
    chk("dual_r1", DATA_R1, 32'h3);
    chk("dual_r2", DATA_R2, 32'h1E);

    // Conflict: READ and WRITE together produce zero outputs and no write
    @(negedge CLK);
    READ = 1'b1; WRITE = 1'b1; ADDR_W = 5'd5; DATA_W = 32'hDEADBEEF;
    ADDR_R1 = 5'd5; ADDR_R2 = 5'd6;
    #2;
    chk("conf_pre_r1", DATA_R1, 32'h0);
    chk("conf_pre_r2", DATA_R2, 32'h0);
    @(posedge CLK); #2;
    chk("conf_post_r1", DATA_R1, 32'h0);
    chk("conf_post_r2", DATA_R2, 32'h0);
    @(negedge CLK);
    WRITE = 1'b0;
    #2;
    chk("conf_nowrite_r1", DATA_R1, 32'h5);
    chk("conf_nowrite_r2", DATA_R2, 32'h6);

    // READ=0 forces zero even on populated registers
    READ = 1'b0;
    #1;
    chk("idle_r1", DATA_R1, 32'h0);
    chk("idle_r2", DATA_R2, 32'h0);

    // Write then read on the following half cycle
    @(negedge CLK);
    WRITE = 1'b1; ADDR_W = 5'd7; DATA_W = 32'hA5A5_5A5A;
    @(negedge CLK);
    WRITE = 1'b0; READ = 1'b1; ADDR_R1 = 5'd7; ADDR_R2 = 5'd8;
    #2;
    chk("wr7_r1", DATA_R1, 32'hA5A5_5A5A);
    chk("wr7_r2", DATA_R2, 32'h8);

    // Async reset between edges clears everything immediately
    ADDR_R1 = 5'd3; ADDR_R2 = 5'd30;
    #1 RST = 1'b0;
    #1;
    chk("async_rst_r1", DATA_R1, 32'h0);
    chk("async_rst_r2", DATA_R2, 32'h0);
    // Writes blocked while held in reset
    READ = 1'b0; WRITE = 1'b1; ADDR_W = 5'd9; DATA_W = 32'h1234_5678;
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b1; WRITE = 1'b0; READ = 1'b1; ADDR_R1 = 5'd9; ADDR_R2 = 5'd7;
    #2;
    chk("rst_block_r1", DATA_R1, 32'h0);
    chk("rst_lost_r2", DATA_R2, 32'h0);
    // First write after deassertion is honoured
    READ = 1'b0; WRITE = 1'b1;
    @(negedge CLK);
    WRITE = 1'b0; READ = 1'b1;
    #2;
    chk("post_rst_wr", DATA_R1, 32'h1234_5678);

    // All-ones to addresses 0 and 1
    READ = 1'b0; WRITE = 1'b1; ADDR_W = 5'd0; DATA_W = 32'hFFFF_FFFF;
    @(negedge CLK);
    ADDR_W = 5'd1;
    @(negedge CLK);
    WRITE = 1'b0; READ = 1'b1; ADDR_R1 = 5'd0; ADDR_R2 = 5'd1;
    #2;
`ifdef ZERO_REG_EN
    chk("ones_a0_r1", DATA_R1, 32'h0);
`else
    chk("ones_a0_r1", DATA_R1, 32'hFFFF_FFFF);
`endif
    chk("ones_a1_r2", DATA_R2, 32'hFFFF_FFFF);
    ADDR_R1 = 5'd1; ADDR_R2 = 5'd0;
    #1;
    chk("ones_a1_r1", DATA_R1, 32'hFFFF_FFFF);
`ifdef ZERO_REG_EN
    chk("ones_a0_r2", DATA_R2, 32'h0);
`else
    chk("ones_a0_r2", DATA_R2, 32'hFFFF_FFFF);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/reg_file_32x32.md
# reg_file_32x32

Thirty-two-entry, 32-bit general-purpose register file with two asynchronous read ports and one synchronous write port. It is the processor's architectural register store: the decode stage reads two operands per cycle through R1/R2, and the writeback stage writes one result per cycle. It runs on the single system clock from the clock generator.

## Interface
- DATA_WIDTH, 32, width of each register and of all data ports
- ADDR_WIDTH, 5, register address width
- DEPTH, 32, number of registers (2**ADDR_WIDTH)

- CLK  input  1  system clock, rising-edge active
- RST  input  1  asynchronous, active-low reset; clears all registers
- ADDR_R1  input  5  read port 1 address
- ADDR_R2  input  5  read port 2 address
- ADDR_W  input  5  write address
- DATA_W  input  32  write data
- READ  input  1  read enable
- WRITE  input  1  write enable
- DATA_R1  output  32  read port 1 data
- DATA_R2  output  32  read port 2 data

One clock; reset is asynchronous and active-low (CLK, RST).

## Operation
- Storage: 32 × 32-bit registers, index 0..31.
- Write: on rising CLK with WRITE=1 and READ=0, register[ADDR_W] <= DATA_W.
- Read: when READ=1 and WRITE=0, DATA_R1 = register[ADDR_R1] and DATA_R2 = register[ADDR_R2], combinationally. Both ports are independent, and they may address the same register.
- Idle or conflict: when READ=0, or when READ=1 and WRITE=1, both outputs drive 32'h0. When READ=1 and WRITE=1, no write occurs; the operation is a no-op.
- Reset: RST=0 clears every register to 0 immediately, independent of CLK. While RST=0, writes are blocked. Outputs follow the read rule, so any read returns 0.
- Widths: addresses are full 5-bit, so there is no out-of-range case. Data is stored unmodified.

## Timing
- Write latency: 1 edge. The value is visible on a read port as soon as the edge has passed, within the same cycle, provided READ=1 and WRITE=0.
- Read latency: 0 cycles. Outputs are purely combinational from READ, WRITE, the addresses and storage, and settle well within half a clock period.
- A read of the address being written in the same cycle returns the old value before the edge and the new value after it. No bypass is applied.
- Reset assertion takes effect asynchronously. On deassertion, the first write is honoured at the next rising edge.
- If reset is asserted mid-sequence, all contents are lost. There is no partial-write state.
- Output reset value: 32'h0 on both ports.

## Configuration
- ZERO_REG_EN defined:
  - Register 0 is hardwired to zero.
  - Writes to ADDR_W=0 are discarded.
  - Reads of address 0 return 32'h0 on either port.
- ZERO_REG_EN undefined: register 0 is an ordinary storage register.

## Test plan
- Reset:
  - Stimulus: drive RST=0 for 10 ns, then RST=1; read addresses 0..31 with READ=1, WRITE=0.
  - Required: every read returns 32'h0 on both ports.
- Fill and readback:
  - Stimulus: write DATA_W=i to ADDR_W=i for i=0..31 on consecutive edges; then, for each i, set ADDR_R1=ADDR_R2=i with READ=1.
  - Required: DATA_R1=DATA_R2=i within 5 ns, for 32 passes.
- Dual port:
  - Stimulus: after the fill, set ADDR_R1=3 and ADDR_R2=30.
  - Required: DATA_R1=32'h3 and DATA_R2=32'h1E simultaneously.
- Conflict and idle:
  - Stimulus: READ=1 and WRITE=1 with ADDR_W=5, DATA_W=32'hDEADBEEF across an edge; then READ=1, WRITE=0, ADDR_R1=5.
  - Required: both outputs are 0 during the conflict; the later read returns 32'h5. Outputs are 0 whenever READ=0.
- Async reset mid-operation:
  - Stimulus: after the fill, pulse RST=0 between clock edges.
  - Required: reads of any address return 0 immediately, without waiting for an edge.
- ZERO_REG_EN build:
  - Stimulus: write 32'hFFFFFFFF to address 0 and to address 1.
  - Required: address 0 reads 32'h0; address 1 reads 32'hFFFFFFFF.
